// File: rtl/ball_pair_collision_arbiter.sv
// Ball pair collision arbiter: gathers pixel-level ball overlaps into a pair bitmap
// during a frame, then presents each newly colliding pair, one at a time, afterwards.
module ball_pair_collision_arbiter #(
    parameter int NUM_BALLS       = 3,
    parameter int HOLD_CYCLES     = 2,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_BALLS:0]   ball_drawing_request,
    output logic [NUM_BALLS:0]   balls_collide,
    output logic [1:0][3:0]      Balls_col_ID,
    output logic                 pair_valid,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int NP = (NUM_BALLS + 1) * NUM_BALLS / 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SCAN    = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] CD_INIT   = 3'(COOLDOWN_FRAMES);

    logic [1:0]    state;
    logic [NP-1:0] pending;
    logic [NP-1:0] work;
    logic [3:0]    hold;
    logic [2:0]    cooldown [NP];

    logic [NP-1:0]      det;
    logic               sel_found;
    logic [NP-1:0]      sel_mask;
    logic [NUM_BALLS:0] sel_balls;
    logic [3:0]         sel_lo;
    logic [3:0]         sel_hi;

    // Pair (i,j), i<j, maps to its rank in lexicographic order.
    function automatic int pair_idx(input int i, input int j);
        return i * NUM_BALLS - (i * (i - 1)) / 2 + (j - i - 1);
    endfunction

    assign dbg_state = state;

    always_comb begin
        det = '0;
        for (int i = 0; i <= NUM_BALLS; i++) begin
            for (int j = i + 1; j <= NUM_BALLS; j++) begin
                det[pair_idx(i, j)] = ball_drawing_request[i] & ball_drawing_request[j];
            end
        end
    end

    // Lowest pending pair in the snapshot; outer/inner loops walk pairs in rank order.
    always_comb begin
        sel_found = 1'b0;
        sel_mask  = '0;
        sel_balls = '0;
        sel_lo    = '0;
        sel_hi    = '0;
        for (int i = 0; i <= NUM_BALLS; i++) begin
            for (int j = i + 1; j <= NUM_BALLS; j++) begin
                if (!sel_found && work[pair_idx(i, j)]) begin
                    sel_found              = 1'b1;
                    sel_mask[pair_idx(i, j)] = 1'b1;
                    sel_balls[i]           = 1'b1;
                    sel_balls[j]           = 1'b1;
                    sel_lo                 = 4'(i);
                    sel_hi                 = 4'(j);
                end
            end
        end
    end

    // pair_valid is a pure valid strobe with no ready: the consumer samples the
    // pair on any cycle it is high, and all three pair outputs move together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            pending       <= '0;
            work          <= '0;
            hold          <= '0;
            balls_collide <= '0;
            Balls_col_ID  <= '0;
            pair_valid    <= 1'b0;
            busy          <= 1'b0;
            for (int k = 0; k < NP; k++) begin
                cooldown[k] <= '0;
            end
        end else begin
            pending <= startOfFrame ? det : (pending | det);

            if (startOfFrame) begin
                // Frame boundary takes priority over any presentation in flight.
                for (int k = 0; k < NP; k++) begin
                    work[k] <= pending[k] && (cooldown[k] == 3'd0);
                    if (cooldown[k] != 3'd0) begin
                        cooldown[k] <= pending[k] ? CD_INIT : (cooldown[k] - 3'd1);
                    end
                end
                state         <= SCAN;
                busy          <= 1'b1;
                hold          <= '0;
                balls_collide <= '0;
                Balls_col_ID  <= '0;
                pair_valid    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    SCAN: begin
                        if (!sel_found) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            work            <= work & ~sel_mask;
                            balls_collide   <= sel_balls;
                            Balls_col_ID[0] <= sel_lo;
                            Balls_col_ID[1] <= sel_hi;
                            pair_valid      <= 1'b1;
                            hold            <= HOLD_INIT;
                            state           <= PRESENT;
                            for (int k = 0; k < NP; k++) begin
                                if (sel_mask[k]) begin
                                    cooldown[k] <= CD_INIT;
                                end
                            end
                        end
                    end
                    PRESENT: begin
                        if (hold == 4'd0) begin
                            balls_collide <= '0;
                            Balls_col_ID  <= '0;
                            pair_valid    <= 1'b0;
                            state         <= SCAN;
                        end else begin
                            hold <= hold - 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_pair_collision_arbiter.sv
// Bench for ball_pair_collision_arbiter: directed scenarios then random traffic,
// all checked cycle by cycle against a frame-level presentation timeline model.
module tb_ball_pair_collision_arbiter;

    localparam int NUM_BALLS = 3;
    localparam int HOLD      = 2;
    localparam int CDF       = 4;
    localparam int NB        = NUM_BALLS + 1;
    localparam int NP        = NB * NUM_BALLS / 2;

    logic             clk;
    logic             resetN;
    logic             startOfFrame;
    logic [NB-1:0]    req;
    logic [NB-1:0]    collide;
    logic [1:0][3:0]  ids;
    logic             pair_valid;
    logic             busy;
    logic [1:0]       dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [NB-1:0] collide;
        logic [3:0]    lo;
        logic [3:0]    hi;
        logic          valid;
        logic          busy;
        int            start_k;
    } exp_t;

    exp_t tl[$];
    exp_t cur;
    int   lo_of[NP];
    int   hi_of[NP];
    bit   m_pend[NP];
    int   m_cd[NP];

    ball_pair_collision_arbiter #(
        .NUM_BALLS(NUM_BALLS),
        .HOLD_CYCLES(HOLD),
        .COOLDOWN_FRAMES(CDF)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .ball_drawing_request(req),
        .balls_collide(collide),
        .Balls_col_ID(ids),
        .pair_valid(pair_valid),
        .busy(busy),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int lo, input int hi, input logic valid,
                                input logic b, input int k);
        exp_t e;
        e.collide = '0;
        e.lo      = '0;
        e.hi      = '0;
        if (valid) begin
            e.collide[lo] = 1'b1;
            e.collide[hi] = 1'b1;
            e.lo          = 4'(lo);
            e.hi          = 4'(hi);
        end
        e.valid   = valid;
        e.busy    = b;
        e.start_k = k;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NP; k++) begin
            m_pend[k] = 1'b0;
            m_cd[k]   = 0;
        end
        tl.delete();
        cur = mk(0, 0, 1'b0, 1'b0, -1);
    endtask

    // One clock edge of the reference: at a frame strobe the whole presentation
    // timeline for the new snapshot is laid out; otherwise it is consumed a cycle at a time.
    task automatic model_edge(input bit sof, input logic [NB-1:0] r);
        bit det[NP];
        bit snap[NP];
        for (int k = 0; k < NP; k++) begin
            det[k] = r[lo_of[k]] & r[hi_of[k]];
        end
        if (sof) begin
            for (int k = 0; k < NP; k++) begin
                snap[k] = m_pend[k] && (m_cd[k] == 0);
                if (m_cd[k] > 0) m_cd[k] = m_pend[k] ? CDF : m_cd[k] - 1;
                m_pend[k] = det[k];
            end
            tl.delete();
            tl.push_back(mk(0, 0, 1'b0, 1'b1, -1));
            for (int k = 0; k < NP; k++) begin
                if (snap[k]) begin
                    for (int h = 0; h < HOLD; h++) begin
                        tl.push_back(mk(lo_of[k], hi_of[k], 1'b1, 1'b1, (h == 0) ? k : -1));
                    end
                    tl.push_back(mk(0, 0, 1'b0, 1'b1, -1));
                end
            end
            cur = tl.pop_front();
        end else begin
            for (int k = 0; k < NP; k++) begin
                m_pend[k] = m_pend[k] | det[k];
            end
            if (tl.size() > 0) begin
                cur = tl.pop_front();
                if (cur.start_k >= 0) m_cd[cur.start_k] = CDF;
            end else begin
                cur = mk(0, 0, 1'b0, 1'b0, -1);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_collide"}, 32'(collide), 32'(cur.collide));
        chk({tag, "_id_lo"}, 32'(ids[0]), 32'(cur.lo));
        chk({tag, "_id_hi"}, 32'(ids[1]), 32'(cur.hi));
        chk({tag, "_valid"}, 32'(pair_valid), 32'(cur.valid));
        chk({tag, "_busy"}, 32'(busy), 32'(cur.busy));
    endtask

    task automatic step(input string tag, input bit sof, input logic [NB-1:0] r);
        startOfFrame = sof;
        req          = r;
        @(posedge clk);
        model_edge(sof, r);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) step(tag, 1'b0, '0);
    endtask

    initial begin
        int k;
        k = 0;
        for (int i = 0; i < NB; i++) begin
            for (int j = i + 1; j < NB; j++) begin
                lo_of[k] = i;
                hi_of[k] = j;
                k++;
            end
        end

        resetN       = 1'b1;
        startOfFrame = 1'b0;
        req          = '1;
        model_reset();
        #1 resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        resetN = 1'b1;

        // Single pair (0,1) accumulated over three cycles.
        repeat (3) step("one_pair", 1'b0, 4'b0011);
        step("one_pair", 1'b1, '0);
        idle("one_pair", 6);

        // Three overlapping balls in one cycle give three pairs.
        step("three_pairs", 1'b0, 4'b1110);
        step("three_pairs", 1'b1, '0);
        idle("three_pairs", 12);

        // Cooldown across eleven frames.
        for (int f = 1; f <= 11; f++) begin
            repeat (6) step("cooldown", 1'b0, (f <= 6 || f == 11) ? 4'b0011 : 4'b0000);
            step("cooldown", 1'b1, '0);
        end
        idle("cooldown", 6);

        // Frame strobe aborts presentation of the first of three pairs.
        step("abort", 1'b0, 4'b1110);
        step("abort", 1'b1, '0);
        step("abort", 1'b0, 4'b1100);
        step("abort", 1'b0, 4'b1100);
        step("abort", 1'b1, '0);
        idle("abort", 10);

        // Request coincident with the strobe lands in the next snapshot.
        step("same_cycle", 1'b1, 4'b1001);
        idle("same_cycle", 4);
        step("same_cycle", 1'b1, '0);
        idle("same_cycle", 6);

        // Asynchronous reset during a presentation.
        step("rst_mid", 1'b0, 4'b0101);
        step("rst_mid", 1'b1, '0);
        step("rst_mid", 1'b0, '0);
        step("rst_mid", 1'b0, '0);
        resetN = 1'b0;
        #2;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        resetN = 1'b1;
        step("post_rst", 1'b1, '0);
        idle("post_rst", 4);

        repeat (600) begin
            bit            sof;
            logic [NB-1:0] r;
            sof = ($urandom_range(0, 11) == 0);
            r   = ($urandom_range(0, 2) == 0) ? NB'($urandom_range(0, 15)) : '0;
            step("random", sof, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ball_pair_collision_arbiter.md
BALL_PAIR_COLLISION_ARBITER -- requirements
Module: ball_pair_collision_arbiter

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 3: highest ball index, giving balls 0..NUM_BALLS, 6 pairs at default.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2: cycles each pair is presented; legal range 1..15.
REQ-003 SHALL have parameter COOLDOWN_FRAMES, default 4: frames a presented pair is suppressed; legal range 1..7.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port startOfFrame, input, 1 bit: one-cycle frame strobe.
REQ-007 SHALL have port ball_drawing_request, input, NUM_BALLS+1 bits: bit i set when ball i covers the current pixel.
REQ-008 SHALL have port balls_collide, output, NUM_BALLS+1 bits: exactly the two bits of the presented pair are set, otherwise all zero.
REQ-009 SHALL have port Balls_col_ID, output, 2x4 bits: [0] holds the lower ID and [1] the higher ID of the presented pair, otherwise 0.
REQ-010 SHALL have port pair_valid, output, 1 bit: high while a pair is presented.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 Pair order SHALL be index k in ascending (low, high) lexicographic order: (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
REQ-013 Pending bitmap: on every clk with startOfFrame low, pending[k] SHALL be set for every pair whose both request bits are high; any number of simultaneous bits is allowed, so 3 overlapping balls set 3 pairs.
REQ-014 On a startOfFrame cycle, pending SHALL be replaced by that cycle's detections only; all earlier detections go to the snapshot.
REQ-015 Snapshot at startOfFrame: work[k] SHALL be loaded with pending[k] AND (cooldown[k]==0).
REQ-016 Cooldown update at startOfFrame SHALL use pre-update values: if cooldown[k]!=0 and pending[k]==1, cooldown[k] reloads to COOLDOWN_FRAMES; if cooldown[k]!=0 and pending[k]==0, cooldown[k] decrements by 1.
REQ-017 Cooldown counters SHALL be 3 bits, saturate at 0, and never wrap.
REQ-018 The FSM SHALL have states IDLE, SCAN and PRESENT.
REQ-019 startOfFrame in any state SHALL load work and force SCAN on the next edge; this aborts any presentation in progress, and the outputs clear on that same edge.
REQ-020 SCAN with work==0 SHALL go to IDLE.
REQ-021 SCAN with work!=0 SHALL select the lowest set k, clear work[k], register the outputs, set cooldown[k]=COOLDOWN_FRAMES, load hold=HOLD_CYCLES-1 and go to PRESENT.
REQ-022 PRESENT SHALL hold the outputs; at hold==0 it clears all outputs and goes to SCAN, otherwise it decrements hold.
REQ-023 Consecutive pairs SHALL therefore be separated by exactly one all-zero output cycle.
REQ-024 Timing: with startOfFrame sampled at edge E0, the first pair SHALL be visible after E1 for HOLD_CYCLES cycles.
REQ-025 If startOfFrame and the REQ-021 cooldown set fall on the same edge, the startOfFrame update (REQ-016) SHALL win, and no pair is presented on that edge.
REQ-026 All outputs SHALL be registered; balls_collide, Balls_col_ID and pair_valid SHALL change only together.
REQ-027 Presented pair IDs SHALL always be distinct, and the low ID SHALL always be less than the high ID.

Reset
REQ-028 While resetN is low, state SHALL be IDLE and pending, work, hold, all cooldowns and all outputs SHALL be 0, asynchronously.
REQ-029 Reset deassertion mid-frame SHALL restart accumulation from an empty pending bitmap; the first snapshot occurs at the next startOfFrame.
REQ-030 A ball_drawing_request active during reset SHALL be ignored.

Verification
REQ-031 Bench SHALL cover: requests 4'b0011 for 3 cycles, then startOfFrame -> after E1 the bench sees balls_collide=0011, IDs (0,1), pair_valid=1 for 2 cycles, then zero, then busy=0.
REQ-032 Bench SHALL cover: requests 4'b1110 in one cycle, then startOfFrame -> the bench sees pairs (1,2), (1,3), (2,3) in order, each held 2 cycles with a 1-cycle gap, busy=1 for 10 cycles.
REQ-033 Bench SHALL cover cooldown: pair (0,1) detected in frames 1-6 -> presented after the SOF ending frame 1 only; after frames 2-6 cooldown stays at 4. With no detection in frames 7-10, cooldown counts 3,2,1,0 at the SOFs ending frames 7-10. A detection in frame 11 -> presented again at the SOF ending frame 11.
REQ-034 Bench SHALL cover abort: startOfFrame during PRESENT of the first of 3 pairs -> outputs clear on the next edge, the new snapshot is presented, and old work is discarded.
REQ-035 Bench SHALL cover same-cycle events: requests 4'b1001 coincident with startOfFrame -> not in the current snapshot; presented as (0,3) after the following startOfFrame.
REQ-036 Bench SHALL cover reset mid-PRESENT: resetN low -> all outputs 0 immediately without waiting for clk; after release, startOfFrame with no requests -> pair_valid stays 0.
